// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors round capture stage.
package rps_pkg;

  typedef logic [1:0] choice_t;

  localparam choice_t ROCK     = 2'b00;
  localparam choice_t PAPER    = 2'b01;
  localparam choice_t SCISSORS = 2'b10;
  localparam choice_t ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HOLD     = 2'd2,
    REL_DB   = 2'd3
  } cap_state_t;

  function automatic logic is_legal(choice_t c);
    return c != ILLEGAL;
  endfunction

endpackage

// File: rtl/rps_sync2.sv
// Two-flop synchroniser for a bundle of asynchronous inputs.
module rps_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rps_round_capture.sv
// Debounces the start button, locks both player choices on a clean press and
// offers the round to the game core over valid/ready.
module rps_round_capture
  import rps_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic [1:0] p1_choice_in,
  input  logic [1:0] p2_choice_in,
  input  logic       round_ready,
  output logic       round_valid,
  output logic [1:0] p1_choice,
  output logic [1:0] p2_choice,
  output logic       round_error,
  output logic       busy,
  output logic [7:0] round_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic    [4:0] sync_bus;
  logic          start_s;
  choice_t       p1_s, p2_s;

  rps_sync2 #(.W(5)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({start_in, p1_choice_in, p2_choice_in}),
    .q   (sync_bus)
  );

  assign start_s = sync_bus[4];
  assign p1_s    = sync_bus[3:2];
  assign p2_s    = sync_bus[1:0];

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  choice_t          p1_q, p1_d, p2_q, p2_d;
  logic             err_q, err_d;
  logic [7:0]       count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p1_q    <= ROCK;
      p2_q    <= ROCK;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    err_d   = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: if (start_s) begin
        state_d = PRESS_DB;
        cnt_d   = CNT_W'(1);
      end
      PRESS_DB: begin
        if (!start_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < DB_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Only the synchronised choices at this edge count.
          cnt_d = '0;
          if (is_legal(p1_s) && is_legal(p2_s)) begin
            p1_d    = p1_s;
            p2_d    = p2_s;
            state_d = HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = REL_DB;
          end
        end
      end
      HOLD: if (round_ready) begin
        state_d = REL_DB;
        cnt_d   = '0;
        count_d = count_q + 8'd1;
      end
      REL_DB: begin
        // Must see a full debounced release before another press can start.
        if (start_s) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    round_valid = (state_q == HOLD);
    busy        = (state_q != IDLE);
    p1_choice   = p1_q;
    p2_choice   = p2_q;
    round_error = err_q;
    round_count = count_q;
  end

endmodule

// File: tb/tb_rps_round_capture.sv
// Randomised and directed bench for rps_round_capture with a behavioural model.
module tb_rps_round_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic [1:0] p1_choice_in = 2'b00;
  logic [1:0] p2_choice_in = 2'b00;
  logic       round_ready = 1'b0;
  logic       round_valid;
  logic [1:0] p1_choice;
  logic [1:0] p2_choice;
  logic       round_error;
  logic       busy;
  logic [7:0] round_count;

  rps_round_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .p1_choice_in (p1_choice_in),
    .p2_choice_in (p2_choice_in),
    .round_ready  (round_ready),
    .round_valid  (round_valid),
    .p1_choice    (p1_choice),
    .p2_choice    (p2_choice),
    .round_error  (round_error),
    .busy         (busy),
    .round_count  (round_count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 counting a press, 2 offering a round,
  // 3 waiting for a clean release.
  int         m_mode = 0, m_run = 0, m_p1 = 0, m_p2 = 0, m_err = 0, m_cnt = 0;
  logic [4:0] m_sa = '0, m_sb = '0;
  logic       m_st;
  int         m_c1, m_c2;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_run = 0; m_p1 = 0; m_p2 = 0; m_err = 0; m_cnt = 0;
      m_sa = '0; m_sb = '0;
    end else begin
      m_st = m_sb[4];
      m_c1 = int'(m_sb[3:2]);
      m_c2 = int'(m_sb[1:0]);
      m_err = 0;
      if (m_mode == 0) begin
        if (m_st) begin m_mode = 1; m_run = 1; end
      end else if (m_mode == 1) begin
        if (!m_st) begin m_mode = 0; m_run = 0; end
        else if (m_run < D) m_run++;
        else if (m_c1 == 3 || m_c2 == 3) begin m_err = 1; m_mode = 3; m_run = 0; end
        else begin m_p1 = m_c1; m_p2 = m_c2; m_mode = 2; end
      end else if (m_mode == 2) begin
        if (round_ready) begin m_mode = 3; m_run = 0; m_cnt = (m_cnt + 1) % 256; end
      end else begin
        if (m_st) m_run = 0;
        else begin
          m_run++;
          if (m_run == D) begin m_mode = 0; m_run = 0; end
        end
      end
      m_sb = m_sa;
      m_sa = {start_in, p1_choice_in, p2_choice_in};
    end
  end

  logic [14:0] exp_v, act_v;
  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      exp_v = {(m_mode == 2), (m_mode != 0), 2'(m_p1), 2'(m_p2), 1'(m_err), 8'(m_cnt)};
      act_v = {round_valid, busy, p1_choice, p2_choice, round_error, round_count};
      check("model_cycle", int'(act_v), int'(exp_v));
    end
  end

  task automatic drive(input logic s, input logic [1:0] a, input logic [1:0] b);
    start_in = s; p1_choice_in = a; p2_choice_in = b;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic do_round(input logic [1:0] a, input logic [1:0] b);
    int n;
    n = 0;
    drive(1'b1, a, b);
    while (!round_valid && n < 40) begin @(negedge clk); n++; end
    check("round_timeout", int'(round_valid), 1);
    @(negedge clk);
    drive(1'b0, a, b);
    wait_idle();
  endtask

  int lat, seen_v, seen_e, stable;
  logic [6:0] bounce;
  logic [1:0] ra, rb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(round_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_choices", int'({p1_choice, p2_choice}), 0);
    check("rst_error", int'(round_error), 0);
    check("rst_count", int'(round_count), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press, rock vs paper, held 20 cycles.
    round_ready = 1'b1;
    drive(1'b1, 2'b00, 2'b01);
    lat = 0;
    while (!round_valid && lat < 20) begin @(negedge clk); lat++; end
    check("press_latency", lat, D + 3);
    check("lock_p1", int'(p1_choice), 0);
    check("lock_p2", int'(p2_choice), 1);
    @(negedge clk);
    check("valid_one_cycle", int'(round_valid), 0);
    check("count_first", int'(round_count), 1);
    seen_v = 0;
    repeat (12) begin @(negedge clk); seen_v += int'(round_valid); end
    check("no_second_round", seen_v, 0);
    drive(1'b0, 2'b00, 2'b01);
    lat = 0;
    while (busy && lat < 20) begin @(negedge clk); lat++; end
    check("release_latency", lat, D + 2);
    check("count_after_hold", int'(round_count), 1);

    // Bounce shorter than the debounce window.
    bounce = 7'b1101110;
    seen_v = 0; seen_e = 0;
    for (int i = 6; i >= 0; i--) begin
      start_in = bounce[i];
      @(negedge clk);
      seen_v += int'(round_valid); seen_e += int'(round_error);
    end
    start_in = 1'b0;
    repeat (8) begin @(negedge clk); seen_v += int'(round_valid); seen_e += int'(round_error); end
    check("bounce_valid", seen_v, 0);
    check("bounce_error", seen_e, 0);
    check("bounce_count", int'(round_count), 1);
    check("bounce_idle", int'(busy), 0);

    // Illegal choice code.
    drive(1'b1, 2'b10, 2'b11);
    seen_v = 0; seen_e = 0;
    repeat (20) begin @(negedge clk); seen_v += int'(round_valid); seen_e += int'(round_error); end
    drive(1'b0, 2'b10, 2'b11);
    wait_idle();
    check("illegal_err_pulses", seen_e, 1);
    check("illegal_valid", seen_v, 0);
    check("illegal_count", int'(round_count), 1);
    check("illegal_keep_p1", int'(p1_choice), 0);
    check("illegal_keep_p2", int'(p2_choice), 1);

    // Back-pressure with choices toggling while the round is held.
    round_ready = 1'b0;
    ra = 2'($urandom_range(0, 2)); rb = 2'($urandom_range(0, 2));
    drive(1'b1, ra, rb);
    lat = 0;
    while (!round_valid && lat < 20) begin @(negedge clk); lat++; end
    check("bp_valid_rise", int'(round_valid), 1);
    stable = 1;
    repeat (10) begin
      drive(1'b1, 2'($urandom), 2'($urandom));
      @(negedge clk);
      if (!round_valid || p1_choice != ra || p2_choice != rb) stable = 0;
    end
    check("bp_stable", stable, 1);
    check("bp_count_before", int'(round_count), 1);
    round_ready = 1'b1;
    @(negedge clk);
    check("bp_accepted", int'(round_valid), 0);
    check("bp_count_after", int'(round_count), 2);
    drive(1'b0, 2'b00, 2'b00);
    wait_idle();

    // Asynchronous reset while holding a round.
    round_ready = 1'b0;
    drive(1'b1, 2'b01, 2'b10);
    lat = 0;
    while (!round_valid && lat < 20) begin @(negedge clk); lat++; end
    check("hold_before_rst", int'(round_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(round_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_choices", int'({p1_choice, p2_choice}), 0);
    check("arst_count", int'(round_count), 0);
    drive(1'b0, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    round_ready = 1'b1;
    @(negedge clk);
    do_round(2'b01, 2'b10);
    check("post_rst_p1", int'(p1_choice), 1);
    check("post_rst_p2", int'(p2_choice), 2);
    check("post_rst_count", int'(round_count), 1);

    // 255 more acceptances wrap the counter to zero.
    for (int i = 0; i < 255; i++) do_round(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
    check("count_wrap", int'(round_count), 0);

    // Random stimulus: button runs, random choices (incl. illegal), random ready.
    for (int r = 0; r < 400; r++) begin
      start_in = 1'($urandom);
      p1_choice_in = 2'($urandom);
      p2_choice_in = 2'($urandom);
      repeat ($urandom_range(1, 9)) begin
        round_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 5) == 0) begin
          p1_choice_in = 2'($urandom);
          p2_choice_in = 2'($urandom);
        end
        @(negedge clk);
      end
    end
    start_in = 1'b0;
    round_ready = 1'b1;
    wait_idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
